// File: rtl/hash_seq_fsm_if.sv
// Handshake bundle for hash_seq_fsm: request queue, bus arbiter/data bus and completion queue.
// The master modport is the sequencer; the slave modport is its environment.
interface hash_seq_fsm_if #(
   parameter int ADDRW = 24,
   parameter int CNTW  = 8
);
   logic                    req_valid;
   logic [2*ADDRW+CNTW:0]   req_data;
   logic                    ready_req_out;
   logic                    arb_req;
   logic                    arb_grant;
   logic [2:0]              ack_in;
   logic [ADDRW+7:0]        data_out;
   logic                    comq_ready_in;
   logic                    valid_compq_out;
   logic [ADDRW+1:0]        compq_data_out;
   logic                    busy;

   modport master (
      input  req_valid, req_data, arb_grant, ack_in, comq_ready_in,
      output ready_req_out, arb_req, data_out, valid_compq_out, compq_data_out, busy
   );

   modport slave (
      output req_valid, req_data, arb_grant, ack_in, comq_ready_in,
      input  ready_req_out, arb_req, data_out, valid_compq_out, compq_data_out, busy
   );
endinterface

// File: rtl/hash_seq_fsm.sv
// Multi-block hash command sequencer: one request -> N x (memory read, hash block) -> digest write
// -> status-tagged completion, with a per-wait watchdog that turns a lost ACK into a timeout status.
module hash_seq_fsm #(
   parameter int         ADDRW     = 24,
   parameter int         CNTW      = 8,
   parameter int         BLK_BYTES = 64,
   parameter logic [1:0] ACCEL_ID  = 2'b01,
   parameter logic [1:0] MEM_ID    = 2'b00,
   parameter int         TIMEOUT   = 1024
) (
   input logic            clk,
   input logic            rst,
   hash_seq_fsm_if.master bus
);

   localparam int TW  = $clog2(TIMEOUT) + 1;
   localparam int CW1 = CNTW + 1;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_BADLEN  = 2'b10;

   localparam logic [1:0] OP_RD   = 2'b01;
   localparam logic [1:0] OP_WR   = 2'b10;
   localparam logic [1:0] OP_HASH = 2'b11;

   typedef enum logic [2:0] {
      IDLE, RD, WAIT_RD, HASH, WAIT_HASH, WR, WAIT_WR, COMPLETE
   } state_t;

   state_t state_q, state_d;

   logic [ADDRW-1:0] dst_q;
   logic [ADDRW-1:0] cur_src_q;
   logic [CNTW-1:0]  nblk_q;
   logic             mode_q;
   logic [CNTW-1:0]  blk_cnt_q;
   logic [1:0]       status_q;
   logic [TW-1:0]    timer_q;

   logic [ADDRW-1:0] req_dst;
   logic [ADDRW-1:0] req_src;
   logic [CNTW-1:0]  req_nblk;
   logic             req_mode;
   logic             ack_mem;
   logic             ack_acc;
   logic             timer_exp;
   logic             last_blk;

   function automatic logic [ADDRW+7:0] cmd_word(input logic [1:0] op,
                                                  input logic [1:0] src_id,
                                                  input logic [1:0] dst_id,
                                                  input logic [1:0] flags,
                                                  input logic [ADDRW-1:0] addr);
      return {addr, flags, dst_id, src_id, op};
   endfunction

   assign req_dst   = bus.req_data[ADDRW-1:0];
   assign req_src   = bus.req_data[2*ADDRW-1:ADDRW];
   assign req_nblk  = bus.req_data[2*ADDRW+CNTW-1:2*ADDRW];
   assign req_mode  = bus.req_data[2*ADDRW+CNTW];
   assign ack_mem   = (bus.ack_in == {1'b1, MEM_ID});
   assign ack_acc   = (bus.ack_in == {1'b1, ACCEL_ID});
   assign timer_exp = (timer_q == TW'(TIMEOUT - 1));
   assign last_blk  = (({1'b0, blk_cnt_q} + CW1'(1)) >= {1'b0, nblk_q});

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---- next-state logic; a matching ACK takes priority over watchdog expiry ----
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (bus.req_valid) state_d = (req_nblk == '0) ? COMPLETE : RD;
         RD:        if (bus.arb_grant) state_d = WAIT_RD;
         WAIT_RD:   if (ack_mem) state_d = HASH;
                    else if (timer_exp) state_d = COMPLETE;
         HASH:      if (bus.arb_grant) state_d = WAIT_HASH;
         WAIT_HASH: if (ack_acc) state_d = last_blk ? WR : RD;
                    else if (timer_exp) state_d = COMPLETE;
         WR:        if (bus.arb_grant) state_d = WAIT_WR;
         WAIT_WR:   if (ack_mem || timer_exp) state_d = COMPLETE;
         COMPLETE:  if (bus.comq_ready_in) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // ---- control fields: status, block counter, watchdog timer ----
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q  <= ST_OK;
         blk_cnt_q <= '0;
         timer_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (bus.req_valid) begin
               status_q  <= (req_nblk == '0) ? ST_BADLEN : ST_OK;
               blk_cnt_q <= '0;
            end
            RD, HASH, WR: if (bus.arb_grant) timer_q <= '0;
            WAIT_RD, WAIT_WR: if (!ack_mem) begin
               if (timer_exp) status_q <= ST_TIMEOUT;
               else           timer_q  <= timer_q + TW'(1);
            end
            WAIT_HASH: begin
               if (ack_acc)        blk_cnt_q <= blk_cnt_q + CNTW'(1);
               else if (timer_exp) status_q  <= ST_TIMEOUT;
               else                timer_q   <= timer_q + TW'(1);
            end
            default: ;
         endcase
      end
   end

   // ---- request fields; no reset needed, only read outside IDLE ----
   always_ff @(posedge clk) begin
      if (state_q == IDLE && bus.req_valid) begin
         dst_q     <= req_dst;
         cur_src_q <= req_src;
         nblk_q    <= req_nblk;
         mode_q    <= req_mode;
      end else if (state_q == WAIT_HASH && ack_acc) begin
         cur_src_q <= cur_src_q + ADDRW'(BLK_BYTES);
      end
   end

   // ---- Moore outputs ----
   always_comb begin
      bus.ready_req_out   = 1'b0;
      bus.arb_req         = 1'b0;
      bus.data_out        = '0;
      bus.valid_compq_out = 1'b0;
      bus.compq_data_out  = '0;
      bus.busy            = (state_q != IDLE);
      unique case (state_q)
         IDLE:      bus.ready_req_out = 1'b1;
         RD: begin
            bus.arb_req  = 1'b1;
            bus.data_out = cmd_word(OP_RD, MEM_ID, ACCEL_ID, 2'b00, cur_src_q);
         end
         WAIT_RD:   bus.data_out = cmd_word(OP_RD, MEM_ID, ACCEL_ID, 2'b00, cur_src_q);
         HASH: begin
            bus.arb_req  = 1'b1;
            bus.data_out = cmd_word(OP_HASH, 2'b00, ACCEL_ID, {mode_q, blk_cnt_q == '0}, '0);
         end
         WAIT_HASH: bus.data_out = cmd_word(OP_HASH, 2'b00, ACCEL_ID, {mode_q, blk_cnt_q == '0}, '0);
         WR: begin
            bus.arb_req  = 1'b1;
            bus.data_out = cmd_word(OP_WR, ACCEL_ID, MEM_ID, 2'b00, dst_q);
         end
         WAIT_WR:   bus.data_out = cmd_word(OP_WR, ACCEL_ID, MEM_ID, 2'b00, dst_q);
         COMPLETE: begin
            bus.valid_compq_out = 1'b1;
            bus.compq_data_out  = {status_q, dst_q};
         end
         default: ;
      endcase
   end

endmodule
